mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory pipeline stage: consumes exe_to_mem_t from execute, issues loads/stores to a
//  valid/ready data-memory port, aligns and extends load data, and registers one
//  mem_to_wb_t per instruction for writeback. Stalls execute while an access is in flight.
// PARAMETERS
//  ADDR_W  32  data-memory address width (bus32_t addresses; upper bits passed through)
// PORTS
//  clk_i             in   1    single clock, all state on rising edge
//  rstn_i            in   1    reset, asynchronous assert, active-low
//  exe_to_mem_i      in   $bits(exe_to_mem_t)  instruction + result (address) + store_data
//  exe_valid_i       in   1    exe_to_mem_i holds a valid instruction
//  mem_ready_o       out  1    stage accepts exe_to_mem_i this cycle
//  dmem_req_valid_o  out  1    request valid
//  dmem_req_ready_i  in   1    memory accepts request
//  dmem_req_addr_o   out  32   word-aligned address ({addr[31:2],2'b00})
//  dmem_req_we_o     out  1    1 = store
//  dmem_req_be_o     out  4    byte enables
//  dmem_req_wdata_o  out  32   lane-replicated store data
//  dmem_rsp_valid_i  in   1    load data valid (loads only)
//  dmem_rsp_data_i   in   32   load word
//  mem_to_wb_o       out  $bits(mem_to_wb_t)  instr + final result
//  wb_valid_o        out  1    mem_to_wb_o valid, one-cycle pulse per instruction
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except mem_ready_o=1. Async, may hit any state.
//  FSM IDLE -> REQ -> WAIT -> IDLE. mem_ready_o = (state==IDLE).
//  IDLE, exe_valid_i, mem_op==MEM_NONE: register instr/result -> wb_valid_o next cycle (1-cycle latency).
//  IDLE, exe_valid_i, LOAD/STORE: capture instr, go REQ; dmem_req_valid_o=1 from next cycle.
//  REQ: all dmem_req_* held stable until dmem_req_ready_i. On accept: store -> IDLE with
//   wb_valid_o pulse (write_enable forced 0); load -> WAIT. Store min latency 2 cycles.
//  WAIT: on dmem_rsp_valid_i -> extract, extend, wb_valid_o pulse, IDLE. Load min latency 3.
//  Memory never returns a response in the accept cycle; dmem_rsp_valid_i in IDLE/REQ ignored.
//  Byte enables: BYTE 4'b0001<<a[1:0]; HALF 4'b0011<<{a[1],1'b0}; WORD 4'b1111.
//  wdata: BYTE {4{d[7:0]}}, HALF {2{d[15:0]}}, WORD d.
//  Load: lane = rsp >> {a[1:0],3'b000}; BYTE/HALF sign- or zero-extend per mem_unsigned.
//  No downstream backpressure: writeback always accepts. wb_valid_o low in every other cycle.
//  Reset mid-REQ/WAIT: access abandoned, no wb pulse; late response dropped (arrives in IDLE).
// CONFIGURATION
//  MEM_STAGE_ALIGN_CHECK_EN defined: HALF with a[0]!=0 or WORD with a[1:0]!=0 issues no
//   request; 1-cycle pass-through with misaligned flag set in mem_to_wb_t, result=address,
//   write_enable=0. Undefined: flag tied 0; low address bits ignored per size
//   (HALF uses a[1], WORD uses lane 0), access issued normally.
// STRUCTURE
//  tartaruga_pkg additions: mem_op_t {MEM_NONE,MEM_LOAD,MEM_STORE}; mem_size_t
//   {BYTE,HALF,WORD}; instr_data_t gains mem_op, mem_size, mem_unsigned; exe_to_mem_t gains
//   bus32_t store_data; mem_to_wb_t {instr_data_t instr; bus32_t result; logic misaligned}.
//  Sub-module mem_align (combinational): be/wdata generation, load extract/extend, misalign.
//  mem_stage holds FSM, captured instruction register and output register.
// TESTING
//  ALU op, result 0x1234 -> wb_valid_o next cycle, result 0x1234, no dmem request.
//  LW @0x100, ready at once, rsp 2 cycles later 0xDEADBEEF -> result 0xDEADBEEF, mem_ready_o low throughout.
//  SB data 0xAB @0x103 -> be 4'b1000, wdata 0xABABABAB, addr 0x100, write_enable 0 at wb.
//  LH @0x102 rsp 0x80010000 -> 0xFFFF8001; LHU same -> 0x00008001; LB @0x101 rsp 0x00007F00 -> 0x7F.
//  req_ready low 5 cycles -> request fields stable, exe stalled, single wb pulse afterwards.
//  rstn_i low in WAIT, rsp arrives after release -> no wb_valid_o; with _EN, LW @0x102 -> misaligned=1, no request.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// ============================================================================
//  Module   : tartaruga_pkg
//  Purpose  : Shared types for the tartaruga pipeline (execute -> mem -> wb).
//  Revision : 1.0  initial memory-stage types
// ============================================================================
`default_nettype none

package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        bus32_t    pc;
        logic [4:0] rd;
        logic      write_enable;
        mem_op_t   mem_op;
        mem_size_t mem_size;
        logic      mem_unsigned;
    } instr_data_t;

    typedef struct packed {
        instr_data_t instr;
        bus32_t      result;
        bus32_t      store_data;
    } exe_to_mem_t;

    typedef struct packed {
        instr_data_t instr;
        bus32_t      result;
        logic        misaligned;
    } mem_to_wb_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_align.sv
// ============================================================================
//  Module   : mem_align
//  Purpose  : Byte-enable / store-data lane replication, load extract and
//             extend, misalignment detect (MEM_STAGE_ALIGN_CHECK_EN).
//  Revision : 1.0  initial
// ============================================================================
`default_nettype none

module mem_align
    import tartaruga_pkg::*;
(
    input  logic [1:0] i_addr_lo,
    input  mem_size_t  i_size,
    input  logic       i_unsigned,
    input  bus32_t     i_store_data,
    input  bus32_t     i_rsp_data,
    output logic [3:0] o_be,
    output bus32_t     o_wdata,
    output bus32_t     o_load_data,
    output logic       o_misaligned
);

    logic [1:0] w_lane;
    bus32_t     w_shifted;

    always_comb begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        w_lane      = 2'b00;
        case (i_size)
            BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
                w_lane  = i_addr_lo;
            end
            HALF: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_store_data[15:0]}};
                w_lane  = {i_addr_lo[1], 1'b0};
            end
            default: ;
        endcase

        w_shifted   = i_rsp_data >> {w_lane, 3'b000};
        o_load_data = w_shifted;
        case (i_size)
            BYTE:    o_load_data = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            HALF:    o_load_data = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    always_comb begin
        o_misaligned = 1'b0;
        case (i_size)
            HALF:    o_misaligned = i_addr_lo[0];
            WORD:    o_misaligned = |i_addr_lo;
            default: ;
        endcase
    end
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory pipeline stage: issues loads/stores on a valid/ready port,
//             aligns load data, registers one writeback record per instruction.
//             Optional misalignment trap: define MEM_STAGE_ALIGN_CHECK_EN.
//  Revision : 1.0  initial
// ============================================================================
`default_nettype none

module mem_stage
    import tartaruga_pkg::*;
#(
    parameter int ADDR_W = 32
)(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  exe_to_mem_t       exe_to_mem_i,
    input  logic              exe_valid_i,
    output logic              mem_ready_o,
    output logic              dmem_req_valid_o,
    input  logic              dmem_req_ready_i,
    output logic [ADDR_W-1:0] dmem_req_addr_o,
    output logic              dmem_req_we_o,
    output logic [3:0]        dmem_req_be_o,
    output bus32_t            dmem_req_wdata_o,
    input  logic              dmem_rsp_valid_i,
    input  bus32_t            dmem_rsp_data_i,
    output mem_to_wb_t        mem_to_wb_o,
    output logic              wb_valid_o
);

    mem_state_t  r_state;
    mem_state_t  w_state_nxt;
    exe_to_mem_t r_cap;
    mem_to_wb_t  r_wb;
    logic        r_wb_valid;

    mem_to_wb_t  w_wb_nxt;
    logic        w_wb_fire;
    logic        w_capture;

    logic        w_idle;
    logic        w_in_req;
    logic [1:0]  w_addr_lo;
    mem_size_t   w_size;
    logic        w_unsigned;
    bus32_t      w_store_data;
    logic [3:0]  w_be;
    bus32_t      w_wdata;
    bus32_t      w_load_data;
    logic        w_align_mis;
    logic        w_is_mem;
    logic        w_misaligned;
    logic        w_issue;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_in_req = (r_state == ST_REQ);

    // In IDLE the aligner looks at the incoming instruction (misalign check);
    // afterwards it works from the captured copy so request fields stay stable.
    assign w_addr_lo    = w_idle ? exe_to_mem_i.result[1:0]         : r_cap.result[1:0];
    assign w_size       = w_idle ? exe_to_mem_i.instr.mem_size      : r_cap.instr.mem_size;
    assign w_unsigned   = w_idle ? exe_to_mem_i.instr.mem_unsigned  : r_cap.instr.mem_unsigned;
    assign w_store_data = w_idle ? exe_to_mem_i.store_data          : r_cap.store_data;

    mem_align u_align (
        .i_addr_lo    (w_addr_lo),
        .i_size       (w_size),
        .i_unsigned   (w_unsigned),
        .i_store_data (w_store_data),
        .i_rsp_data   (dmem_rsp_data_i),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data),
        .o_misaligned (w_align_mis)
    );

    assign w_is_mem     = (exe_to_mem_i.instr.mem_op != MEM_NONE);
    assign w_misaligned = w_is_mem & w_align_mis;
    assign w_issue      = exe_valid_i & w_is_mem & ~w_misaligned;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_wb_fire   = 1'b0;
        w_wb_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (exe_valid_i) begin
                    w_wb_fire           = 1'b1;
                    w_wb_nxt.instr      = exe_to_mem_i.instr;
                    w_wb_nxt.result     = exe_to_mem_i.result;
                    w_wb_nxt.misaligned = w_misaligned;
                    if (w_misaligned) begin
                        w_wb_nxt.instr.write_enable = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_req_ready_i) begin
                    if (r_cap.instr.mem_op == MEM_STORE) begin
                        w_wb_fire                   = 1'b1;
                        w_wb_nxt.instr              = r_cap.instr;
                        w_wb_nxt.instr.write_enable = 1'b0;
                        w_wb_nxt.result             = r_cap.result;
                        w_state_nxt                 = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rsp_valid_i) begin
                    w_wb_fire       = 1'b1;
                    w_wb_nxt.instr  = r_cap.instr;
                    w_wb_nxt.result = w_load_data;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cap      <= '0;
            r_wb       <= '0;
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid <= w_wb_fire;
            if (w_wb_fire) begin
                r_wb <= w_wb_nxt;
            end
            if (w_capture) begin
                r_cap <= exe_to_mem_i;
            end
        end
    end

    // Request outputs are forced to zero outside REQ so idle/reset reads as all-zero.
    assign mem_ready_o      = w_idle;
    assign dmem_req_valid_o = w_in_req;
    assign dmem_req_addr_o  = w_in_req ? {r_cap.result[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_req_we_o    = w_in_req & (r_cap.instr.mem_op == MEM_STORE);
    assign dmem_req_be_o    = w_in_req ? w_be : 4'b0000;
    assign dmem_req_wdata_o = w_in_req ? w_wdata : '0;
    assign mem_to_wb_o      = r_wb;
    assign wb_valid_o       = r_wb_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: directed table, corner
//             sequences and random traffic against a behavioural model.
//  Revision : 1.0  initial
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import tartaruga_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    exe_to_mem_t exe_to_mem_i = '0;
    logic        exe_valid_i = 1'b0;
    logic        mem_ready_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i = 1'b0;
    logic [31:0] dmem_req_addr_o;
    logic        dmem_req_we_o;
    logic [3:0]  dmem_req_be_o;
    logic [31:0] dmem_req_wdata_o;
    logic        dmem_rsp_valid_i = 1'b0;
    logic [31:0] dmem_rsp_data_i = '0;
    mem_to_wb_t  mem_to_wb_o;
    logic        wb_valid_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn_i),
        .exe_to_mem_i     (exe_to_mem_i),
        .exe_valid_i      (exe_valid_i),
        .mem_ready_o      (mem_ready_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_req_addr_o  (dmem_req_addr_o),
        .dmem_req_we_o    (dmem_req_we_o),
        .dmem_req_be_o    (dmem_req_be_o),
        .dmem_req_wdata_o (dmem_req_wdata_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_data_i  (dmem_rsp_data_i),
        .mem_to_wb_o      (mem_to_wb_o),
        .wb_valid_o       (wb_valid_o)
    );

    typedef struct {
        mem_op_t     op;
        mem_size_t   sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rsp;
        int          rdy;
        int          rspd;
        logic [31:0] exp_res;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int ref_lane(input mem_size_t sz, input logic [31:0] a);
        if (sz == BYTE) return int'(a % 4);
        if (sz == HALF) return int'(((a % 4) / 2) * 2);
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input mem_size_t sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] rsp);
        logic [31:0] v;
        v = rsp >> (8 * ref_lane(sz, a));
        if (sz == BYTE) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == HALF) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input mem_size_t sz, input logic [31:0] a);
        int w;
        w = (sz == BYTE) ? 1 : (sz == HALF) ? 2 : 4;
        return 4'((2 ** w - 1) << ref_lane(sz, a));
    endfunction

    function automatic logic [31:0] ref_wdata(input mem_size_t sz, input logic [31:0] d);
        if (sz == BYTE) return (d % 256) * 32'h0101_0101;
        if (sz == HALF) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic ref_mis(input mem_op_t op, input mem_size_t sz, input logic [31:0] a);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        if (op == MEM_NONE) return 1'b0;
        if (sz == HALF) return (a % 2) != 0;
        if (sz == WORD) return (a % 4) != 0;
        return 1'b0;
`else
        return (op == MEM_NONE) ? 1'b0 : 1'b0;
`endif
    endfunction

    function automatic vec_t mkv(input mem_op_t op, input mem_size_t sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rsp, input int rdy, input int rspd,
                                 input logic [31:0] exp_res, input logic [3:0] exp_be,
                                 input logic [31:0] exp_wdata);
        vec_t v;
        v.op = op; v.sz = sz; v.uns = uns; v.addr = addr; v.sdata = sdata; v.rsp = rsp;
        v.rdy = rdy; v.rspd = rspd; v.exp_res = exp_res; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Drive one instruction, play the memory, check the writeback record and request.
    task automatic run(input vec_t v, input string tag);
        logic [31:0] q_addr, q_wdata;
        logic [3:0]  q_be;
        logic        q_we, saw_req, acc, got, stable, stall_ok, mis, exp_we;
        int          reqc, since, lat, exp_lat;
        mem_to_wb_t  wb;
        logic [4:0]  rd;

        q_addr = '0; q_wdata = '0; q_be = '0; q_we = 1'b0; wb = '0;
        saw_req = 1'b0; acc = 1'b0; got = 1'b0; stable = 1'b1; stall_ok = 1'b1;
        reqc = 0; since = 0; lat = 0;
        mis = ref_mis(v.op, v.sz, v.addr);
        rd  = 5'($urandom_range(1, 31));

        @(negedge clk);
        chk($sformatf("%s_ready_idle", tag), {31'b0, mem_ready_o}, 32'd1);
        exe_to_mem_i                    = '0;
        exe_to_mem_i.instr.pc           = $urandom;
        exe_to_mem_i.instr.rd           = rd;
        exe_to_mem_i.instr.write_enable = 1'b1;
        exe_to_mem_i.instr.mem_op       = v.op;
        exe_to_mem_i.instr.mem_size     = v.sz;
        exe_to_mem_i.instr.mem_unsigned = v.uns;
        exe_to_mem_i.result             = v.addr;
        exe_to_mem_i.store_data         = v.sdata;
        exe_valid_i                     = 1'b1;

        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            exe_valid_i      = 1'b0;
            dmem_req_ready_i = 1'b0;
            dmem_rsp_valid_i = 1'b0;
            dmem_rsp_data_i  = $urandom;
            if (wb_valid_o) begin
                got = 1'b1; wb = mem_to_wb_o; lat = c + 1;
                break;
            end
            if (dmem_req_valid_o) begin
                if (!saw_req) begin
                    q_addr = dmem_req_addr_o; q_be = dmem_req_be_o;
                    q_wdata = dmem_req_wdata_o; q_we = dmem_req_we_o;
                end else if (q_addr !== dmem_req_addr_o || q_be !== dmem_req_be_o ||
                             q_wdata !== dmem_req_wdata_o || q_we !== dmem_req_we_o) begin
                    stable = 1'b0;
                end
                saw_req = 1'b1;
                if (mem_ready_o) stall_ok = 1'b0;
                if (reqc >= v.rdy) begin
                    dmem_req_ready_i = 1'b1;
                    acc = 1'b1;
                end else begin
                    dmem_rsp_valid_i = 1'b1;   // stray response while in REQ must be ignored
                end
                reqc++;
            end else if (acc) begin
                if (mem_ready_o) stall_ok = 1'b0;
                since++;
                if (since >= v.rspd) begin
                    dmem_rsp_valid_i = 1'b1;
                    dmem_rsp_data_i  = v.rsp;
                end
            end
        end

        if (v.op == MEM_NONE || mis) exp_lat = 1;
        else if (v.op == MEM_STORE)  exp_lat = 2 + v.rdy;
        else                         exp_lat = 2 + v.rdy + v.rspd;
        exp_we = (v.op == MEM_STORE || mis) ? 1'b0 : 1'b1;

        chk($sformatf("%s_wb_seen", tag), {31'b0, got}, 32'd1);
        if (got) begin
            chk($sformatf("%s_result", tag), wb.result, v.exp_res);
            chk($sformatf("%s_we", tag), {31'b0, wb.instr.write_enable}, {31'b0, exp_we});
            chk($sformatf("%s_misaligned", tag), {31'b0, wb.misaligned}, {31'b0, mis});
            chk($sformatf("%s_rd", tag), {27'b0, wb.instr.rd}, {27'b0, rd});
            chk($sformatf("%s_latency", tag), lat, exp_lat);
        end
        if (v.op != MEM_NONE && !mis) begin
            chk($sformatf("%s_req_seen", tag), {31'b0, saw_req}, 32'd1);
            chk($sformatf("%s_req_addr", tag), q_addr, {v.addr[31:2], 2'b00});
            chk($sformatf("%s_req_be", tag), {28'b0, q_be}, {28'b0, v.exp_be});
            chk($sformatf("%s_req_we", tag), {31'b0, q_we}, {31'b0, v.op == MEM_STORE});
            if (v.op == MEM_STORE)
                chk($sformatf("%s_req_wdata", tag), q_wdata, v.exp_wdata);
            chk($sformatf("%s_req_stable", tag), {31'b0, stable}, 32'd1);
            chk($sformatf("%s_exe_stalled", tag), {31'b0, stall_ok}, 32'd1);
        end else begin
            chk($sformatf("%s_no_req", tag), {31'b0, saw_req}, 32'd0);
        end

        @(negedge clk);
        dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0;
        chk($sformatf("%s_single_pulse", tag), {31'b0, wb_valid_o}, 32'd0);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t        v;
        int          pulses;
        logic [31:0] ref_res;

        // --- directed table: {op, size, uns, addr, sdata, rsp, rdy, rspd, result, be, wdata}
        tbl.push_back(mkv(MEM_NONE,  WORD, 1'b0, 32'h0000_1234, 32'h0,         32'h0,         0, 1, 32'h0000_1234, 4'h0,    32'h0));
        tbl.push_back(mkv(MEM_LOAD,  WORD, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 2, 32'hDEAD_BEEF, 4'b1111, 32'h0));
        tbl.push_back(mkv(MEM_STORE, BYTE, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0,         0, 1, 32'h0000_0103, 4'b1000, 32'hABAB_ABAB));
        tbl.push_back(mkv(MEM_LOAD,  HALF, 1'b0, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 1, 32'hFFFF_8001, 4'b1100, 32'h0));
        tbl.push_back(mkv(MEM_LOAD,  HALF, 1'b1, 32'h0000_0102, 32'h0,         32'h8001_0000, 1, 1, 32'h0000_8001, 4'b1100, 32'h0));
        tbl.push_back(mkv(MEM_LOAD,  BYTE, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_7F00, 0, 3, 32'h0000_007F, 4'b0010, 32'h0));
        tbl.push_back(mkv(MEM_STORE, WORD, 1'b0, 32'h0000_0200, 32'h1122_3344, 32'h0,         5, 1, 32'h0000_0200, 4'b1111, 32'h1122_3344));
        tbl.push_back(mkv(MEM_STORE, HALF, 1'b0, 32'h0000_0206, 32'h5555_CAFE, 32'h0,         2, 1, 32'h0000_0206, 4'b1100, 32'hCAFE_CAFE));
        tbl.push_back(mkv(MEM_LOAD,  BYTE, 1'b1, 32'h0000_0103, 32'h0,         32'h8000_0000, 5, 2, 32'h0000_0080, 4'b1000, 32'h0));
        tbl.push_back(mkv(MEM_LOAD,  BYTE, 1'b0, 32'h0000_0103, 32'h0,         32'h8000_0000, 0, 1, 32'hFFFF_FF80, 4'b1000, 32'h0));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        tbl.push_back(mkv(MEM_LOAD,  WORD, 1'b0, 32'h0000_0102, 32'h0,         32'h0,         0, 1, 32'h0000_0102, 4'b0000, 32'h0));
`else
        tbl.push_back(mkv(MEM_LOAD,  WORD, 1'b0, 32'h0000_0102, 32'h0,         32'hCAFE_F00D, 0, 1, 32'hCAFE_F00D, 4'b1111, 32'h0));
`endif

        // --- reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_ready", {31'b0, mem_ready_o}, 32'd1);
        chk("rst_req_valid", {31'b0, dmem_req_valid_o}, 32'd0);
        chk("rst_req_addr",  dmem_req_addr_o, 32'd0);
        chk("rst_req_be",    {28'b0, dmem_req_be_o}, 32'd0);
        chk("rst_req_wdata", dmem_req_wdata_o, 32'd0);
        chk("rst_req_we",    {31'b0, dmem_req_we_o}, 32'd0);
        chk("rst_wb_valid",  {31'b0, wb_valid_o}, 32'd0);
        chk("rst_wb_data",   {31'b0, |mem_to_wb_o}, 32'd0);
        rstn_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

        // --- reset while waiting for a load response
        @(negedge clk);
        exe_to_mem_i                    = '0;
        exe_to_mem_i.instr.write_enable = 1'b1;
        exe_to_mem_i.instr.mem_op       = MEM_LOAD;
        exe_to_mem_i.instr.mem_size     = WORD;
        exe_to_mem_i.result             = 32'h0000_0300;
        exe_valid_i                     = 1'b1;
        @(negedge clk);
        exe_valid_i = 1'b0;
        chk("rstwait_req_valid", {31'b0, dmem_req_valid_o}, 32'd1);
        dmem_req_ready_i = 1'b1;
        @(negedge clk);
        dmem_req_ready_i = 1'b0;
        chk("rstwait_in_wait", {30'b0, dmem_req_valid_o, mem_ready_o}, 32'd0);
        #2 rstn_i = 1'b0;
        #1;
        chk("rstwait_async_ready", {31'b0, mem_ready_o}, 32'd1);
        pulses = 0;
        @(negedge clk);
        rstn_i = 1'b1;
        @(negedge clk);
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_data_i  = 32'h1357_9BDF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dmem_rsp_valid_i = 1'b0;
            if (wb_valid_o) pulses++;
        end
        chk("rstwait_no_wb", pulses, 0);

        // --- random traffic against the model
        for (int i = 0; i < 40; i++) begin
            v.op    = mem_op_t'($urandom_range(0, 2));
            v.sz    = mem_size_t'($urandom_range(0, 2));
            v.uns   = 1'($urandom_range(0, 1));
            v.addr  = $urandom % 32'h0001_0000;
            v.sdata = $urandom;
            v.rsp   = $urandom;
            v.rdy   = $urandom_range(0, 3);
            v.rspd  = $urandom_range(1, 3);
            if (v.op == MEM_LOAD && !ref_mis(v.op, v.sz, v.addr))
                ref_res = ref_load(v.sz, v.uns, v.addr, v.rsp);
            else
                ref_res = v.addr;
            v.exp_res   = ref_res;
            v.exp_be    = ref_be(v.sz, v.addr);
            v.exp_wdata = ref_wdata(v.sz, v.sdata);
            run(v, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
